axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-port AXI read arbiter, one outstanding burst
module axi_rd_arbiter #(
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [2:0]  s0_arsize,
    input  logic [1:0]  s0_arburst,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rlast,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [2:0]  s1_arsize,
    input  logic [1:0]  s1_arburst,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rlast,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [1:0]  o_grant,
    output logic        o_len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_ptr;
    logic [7:0]  beat_cnt;
    logic [1:0]  grant;
    logic        len_err;
    logic        any_req;
    logic        win;
    logic        grant_go;
    logic        beat_done;

    // Pick the winner among pending requests; the pointer only breaks ties in round-robin mode
    always_comb begin
        any_req = s0_arvalid | s1_arvalid;
        win     = 1'b0;
        if (s0_arvalid && s1_arvalid) begin
            if (RR != 0) begin
                win = ~last_ptr;
            end else begin
                win = 1'b1;
            end
        end else if (s1_arvalid) begin
            win = 1'b1;
        end
    end

    // Next-state logic; a grant is only issued from IDLE and never while reset is held
    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    grant_go  = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (beat_done && m_axi_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and R-channel routing to the current owner; everything is silenced during reset
    always_comb begin
        s0_arready   = 1'b0;
        s1_arready   = 1'b0;
        m_axi_rready = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        s0_rlast     = 1'b0;
        s1_rlast     = 1'b0;
        if (grant_go) begin
            s0_arready = ~win;
            s1_arready = win;
        end
        if (state == DATA && !rst) begin
            m_axi_rready = (grant[0] & s0_rready) | (grant[1] & s1_rready);
            s0_rvalid    = grant[0] & m_axi_rvalid;
            s1_rvalid    = grant[1] & m_axi_rvalid;
            s0_rlast     = grant[0] & m_axi_rlast;
            s1_rlast     = grant[1] & m_axi_rlast;
        end
    end

    assign beat_done = (state == DATA) && m_axi_rvalid && m_axi_rready;

    assign s0_rdata  = m_axi_rdata;
    assign s1_rdata  = m_axi_rdata;
    assign s0_rresp  = m_axi_rresp;
    assign s1_rresp  = m_axi_rresp;
    assign o_grant   = grant;
    assign o_len_err = len_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // AR issue registers, owner/pointer tracking, beat counting and sticky length check
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_araddr  <= 32'd0;
            m_axi_arlen   <= 8'd0;
            m_axi_arsize  <= 3'd0;
            m_axi_arburst <= 2'd0;
            m_axi_arvalid <= 1'b0;
            grant         <= 2'b00;
            last_ptr      <= 1'b1;
            beat_cnt      <= 8'd0;
            len_err       <= 1'b0;
        end else begin
            if (grant_go) begin
                m_axi_araddr  <= win ? s1_araddr  : s0_araddr;
                m_axi_arlen   <= win ? s1_arlen   : s0_arlen;
                m_axi_arsize  <= win ? s1_arsize  : s0_arsize;
                m_axi_arburst <= win ? s1_arburst : s0_arburst;
                m_axi_arvalid <= 1'b1;
                grant         <= win ? 2'b10 : 2'b01;
                last_ptr      <= win;
            end
            if (state == ADDR && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                beat_cnt      <= 8'd0;
            end
            if (beat_done) begin
                beat_cnt <= beat_cnt + 8'd1;
                if ((m_axi_rlast && beat_cnt != m_axi_arlen) ||
                    (!m_axi_rlast && beat_cnt == m_axi_arlen)) begin
                    len_err <= 1'b1;
                end
                if (m_axi_rlast) begin
                    grant <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized model-checked bench for axi_rd_arbiter
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    function automatic void chk(input int rr, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL rr%0d %s: got 0x%0h, expected 0x%0h", rr, name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int RR_G = (g == 0) ? 1 : 0;

        logic        rst = 1'b1;
        logic [31:0] s0_araddr = '0, s1_araddr = '0;
        logic [7:0]  s0_arlen = '0, s1_arlen = '0;
        logic [2:0]  s0_arsize = '0, s1_arsize = '0;
        logic [1:0]  s0_arburst = '0, s1_arburst = '0;
        logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
        logic        s0_rready = 1'b0, s1_rready = 1'b0;
        logic        s0_arready, s1_arready;
        logic [31:0] s0_rdata, s1_rdata;
        logic [1:0]  s0_rresp, s1_rresp;
        logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
        logic [31:0] m_araddr;
        logic [7:0]  m_arlen;
        logic [2:0]  m_arsize;
        logic [1:0]  m_arburst;
        logic        m_arvalid, m_rready;
        logic        m_arready = 1'b0;
        logic [31:0] m_rdata = '0;
        logic [1:0]  m_rresp = '0;
        logic        m_rlast = 1'b0, m_rvalid = 1'b0;
        logic [1:0]  o_grant;
        logic        o_len_err;

        axi_rd_arbiter #(.RR(RR_G)) dut (
            .clk(clk), .rst(rst),
            .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
            .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
            .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
            .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
            .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
            .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
            .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
            .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
            .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid),
            .m_axi_rready(m_rready),
            .o_grant(o_grant), .o_len_err(o_len_err)
        );

        // Reference model: owner of the outstanding burst (-1 = none), whether its address is still pending
        int          md_owner = -1;
        bit          md_addr  = 1'b0;
        bit          md_last  = 1'b1;
        logic [44:0] md_ar    = '0;
        int          md_beats = 0;
        bit          md_err   = 1'b0;
        bit          run      = 1'b0;
        int          w_now;

        function automatic int pick(input bit v0, input bit v1, input bit last);
            if (v0 && v1) return (RR_G != 0) ? (last ? 0 : 1) : 1;
            return v1 ? 1 : 0;
        endfunction

        always_comb w_now = pick(s0_arvalid, s1_arvalid, md_last);

        always @(posedge clk) begin
            if (rst) begin
                md_owner <= -1;
                md_addr  <= 1'b0;
                md_last  <= 1'b1;
                md_ar    <= '0;
                md_beats <= 0;
                md_err   <= 1'b0;
            end else if (md_owner < 0) begin
                if (s0_arvalid || s1_arvalid) begin
                    md_owner <= w_now;
                    md_addr  <= 1'b1;
                    md_last  <= (w_now == 1);
                    md_ar    <= (w_now == 1) ? {s1_araddr, s1_arlen, s1_arsize, s1_arburst}
                                             : {s0_araddr, s0_arlen, s0_arsize, s0_arburst};
                end
            end else if (md_addr) begin
                if (m_arready) begin
                    md_addr  <= 1'b0;
                    md_beats <= 0;
                end
            end else if (m_rvalid && (md_owner == 0 ? s0_rready : s1_rready)) begin
                if (m_rlast ? (md_beats != int'(md_ar[12:5])) : (md_beats == int'(md_ar[12:5])))
                    md_err <= 1'b1;
                md_beats <= md_beats + 1;
                if (m_rlast) md_owner <= -1;
            end
        end

        logic       in_data, e_s0_arr, e_s1_arr, e_rready, e_s0_rv, e_s1_rv;
        logic [1:0] e_grant;
        always_comb begin
            in_data  = (md_owner >= 0) && !md_addr && !rst;
            e_s0_arr = !rst && (md_owner < 0) && (s0_arvalid || s1_arvalid) && (w_now == 0);
            e_s1_arr = !rst && (md_owner < 0) && (s0_arvalid || s1_arvalid) && (w_now == 1);
            e_rready = in_data && (md_owner == 0 ? s0_rready : s1_rready);
            e_s0_rv  = in_data && (md_owner == 0) && m_rvalid;
            e_s1_rv  = in_data && (md_owner == 1) && m_rvalid;
            e_grant  = (md_owner == 0) ? 2'b01 : ((md_owner == 1) ? 2'b10 : 2'b00);
        end

        bit         sn_ar_hs = 1'b0, sn_r_hs = 1'b0, sn_rlast = 1'b0, sn_s0_hs = 1'b0, sn_s1_hs = 1'b0, sn_rst = 1'b1;
        logic [7:0] sn_arlen = '0;

        // Per-cycle comparison against the model, plus handshake snapshots for the bench-side agents
        always @(negedge clk) begin
            if (run) begin
                chk(RR_G, "arready", 64'({s1_arready, s0_arready}), 64'({e_s1_arr, e_s0_arr}));
                chk(RR_G, "ar_chan", 64'({m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst}), 64'({md_addr, md_ar}));
                chk(RR_G, "grant", 64'(o_grant), 64'(e_grant));
                chk(RR_G, "len_err", 64'(o_len_err), 64'(md_err));
                chk(RR_G, "m_rready", 64'(m_rready), 64'(e_rready));
                chk(RR_G, "rvalid", 64'({s1_rvalid, s0_rvalid}), 64'({e_s1_rv, e_s0_rv}));
                if (e_s0_rv) chk(RR_G, "s0_r", 64'({s0_rdata, s0_rresp, s0_rlast}), 64'({m_rdata, m_rresp, m_rlast}));
                if (e_s1_rv) chk(RR_G, "s1_r", 64'({s1_rdata, s1_rresp, s1_rlast}), 64'({m_rdata, m_rresp, m_rlast}));
            end
            sn_ar_hs <= m_arvalid && m_arready;
            sn_r_hs  <= m_rvalid && m_rready;
            sn_rlast <= m_rlast;
            sn_arlen <= m_arlen;
            sn_s0_hs <= s0_arvalid && s0_arready;
            sn_s1_hs <= s1_arvalid && s1_arready;
            sn_rst   <= rst;
        end

        // Memory slave: arlen+1 beats per accepted AR, optional early rlast, optional forced arready stall
        bit s_act = 1'b0, s_fault = 1'b0;
        int s_beat = 0, s_len = 0, s_hold = 0;

        task automatic slave_drive();
            if (sn_rst) begin
                s_act = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
            end else begin
                if (sn_ar_hs) begin s_act = 1'b1; s_beat = 0; s_len = int'(sn_arlen); end
                if (sn_r_hs) begin s_beat++; if (sn_rlast) s_act = 1'b0; end
                if (!(m_rvalid && !sn_r_hs)) begin
                    m_rvalid = s_act && ($urandom_range(0, 3) != 0);
                    m_rdata  = $urandom;
                    m_rresp  = 2'($urandom_range(0, 3));
                    m_rlast  = (s_beat == (s_fault ? 2 : s_len));
                end
                if (s_hold > 0) begin m_arready = 1'b0; s_hold--; end
                else m_arready = ($urandom_range(0, 2) != 0);
            end
        endtask

        task automatic req_drive(input int pct);
            if (!(s0_arvalid && !sn_s0_hs)) begin
                s0_arvalid = (int'($urandom_range(0, 99)) < pct);
                s0_araddr  = $urandom;
                s0_arlen   = 8'($urandom_range(0, 5));
                s0_arsize  = 3'($urandom_range(0, 7));
                s0_arburst = 2'($urandom_range(0, 3));
            end
            if (!(s1_arvalid && !sn_s1_hs)) begin
                s1_arvalid = (int'($urandom_range(0, 99)) < pct);
                s1_araddr  = $urandom;
                s1_arlen   = 8'($urandom_range(0, 5));
                s1_arsize  = 3'($urandom_range(0, 7));
                s1_arburst = 2'($urandom_range(0, 3));
            end
            s0_rready = ($urandom_range(0, 3) != 0);
            s1_rready = ($urandom_range(0, 3) != 0);
        endtask

        task automatic step();
            @(posedge clk);
            #1;
            slave_drive();
        endtask

        task automatic wait_idle(input string nm);
            int i;
            i = 0;
            while (o_grant != 2'b00 && i < 300) begin step(); i++; end
            chk(RR_G, nm, 64'(o_grant), 64'(0));
        endtask

        initial begin
            int         beats, gi, zeros, i;
            logic [1:0] prev_g;
            logic [1:0] seen [3];
            logic [1:0] exp_seq [3];

            step();
            run = 1'b1;
            s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arsize = 3'd2; s0_arburst = 2'd1;
            s0_rready = 1'b1; s1_rready = 1'b0;
            @(negedge clk);
            chk(RR_G, "reset_arready", 64'(s0_arready), 64'(0));
            chk(RR_G, "reset_outputs", 64'({o_grant, o_len_err, m_arvalid, m_araddr}), 64'(0));
            step();
            rst = 1'b0;
            @(negedge clk);
            chk(RR_G, "s0_arready_T", 64'(s0_arready), 64'(1));
            step();
            s0_arvalid = 1'b0;
            @(negedge clk);
            chk(RR_G, "arvalid_T1", 64'({m_arvalid, m_araddr, m_arlen}), 64'({1'b1, 32'h100, 8'd3}));
            chk(RR_G, "grant_s0", 64'(o_grant), 64'(2'b01));
            beats = 0;
            i = 0;
            while (o_grant != 2'b00 && i < 200) begin
                step();
                @(negedge clk);
                if (s0_rvalid && s0_rready) beats++;
                i++;
            end
            chk(RR_G, "s0_beats", 64'(beats), 64'(4));
            chk(RR_G, "s0_len_ok", 64'({o_grant, o_len_err}), 64'(0));

            step();
            s_hold = 5;
            s0_arvalid = 1'b1; s0_araddr = 32'h200; s0_arlen = 8'd1;
            step();
            s0_arvalid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk(RR_G, "ar_stall_hold", 64'({m_arvalid, m_araddr, m_arlen}), 64'({1'b1, 32'h200, 8'd1}));
                step();
            end
            wait_idle("stall_burst_end");

            rst = 1'b1;
            s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_arlen = 8'd1; s1_arlen = 8'd2;
            s0_rready = 1'b1; s1_rready = 1'b1;
            step();
            rst = 1'b0;
            exp_seq[0] = (RR_G != 0) ? 2'b01 : 2'b10;
            exp_seq[1] = 2'b10;
            exp_seq[2] = exp_seq[0];
            for (int k = 0; k < 3; k++) seen[k] = 2'b00;
            gi = 0; zeros = 0; prev_g = 2'b00; i = 0;
            while (gi < 3 && i < 400) begin
                step();
                @(negedge clk);
                if (o_grant != 2'b00 && prev_g == 2'b00) begin seen[gi] = o_grant; gi++; end
                if (o_grant == 2'b00 && gi > 0 && gi < 3) zeros++;
                prev_g = o_grant;
                i++;
            end
            for (int k = 0; k < 3; k++) chk(RR_G, $sformatf("tie_grant_%0d", k), 64'(seen[k]), 64'(exp_seq[k]));
            chk(RR_G, "idle_gap_cycles", 64'(zeros), 64'(2));
            step();
            s0_arvalid = 1'b0; s1_arvalid = 1'b0;
            wait_idle("tie_end");

            s_fault = 1'b1;
            s0_arvalid = 1'b1; s0_arlen = 8'd3;
            step();
            s0_arvalid = 1'b0;
            wait_idle("fault_end");
            chk(RR_G, "len_err_set", 64'(o_len_err), 64'(1));
            s_fault = 1'b0;
            s1_arvalid = 1'b1; s1_arlen = 8'd5; s1_rready = 1'b1;
            step();
            s1_arvalid = 1'b0;
            i = 0;
            while (m_arvalid && i < 100) begin step(); i++; end
            rst = 1'b1;
            step();
            rst = 1'b0;
            @(negedge clk);
            chk(RR_G, "mid_data_reset", 64'({o_grant, o_len_err, m_arvalid, m_rready, s1_rvalid, m_araddr}), 64'(0));

            for (int k = 0; k < 3000; k++) begin
                step();
                rst = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 49) == 0) s_hold = int'($urandom_range(1, 6));
                req_drive(40);
            end
            step();
            run = 1'b0;
            n_done++;
        end
    end

    initial begin
        wait (n_done == 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete, done=%0d expected 2", n_done);
        $fatal(1);
    end

endmodule
